// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: conversion FSM state enum, blank glyph, BCD nibble width and
// a helper that returns the largest displayable value for a digit count.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int unsigned NIB_W = 4;

  // Largest value that fits in num_digits decimal digits: 10^n - 1.
  function automatic int unsigned bcd_max(input int unsigned num_digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < num_digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the CPU display register and the controller.
// Signals: load_valid (value offered), load_ready (controller idle),
// load_data (unsigned binary value, BIN_W bits).
// Modports: master drives valid/data, slave drives ready.
interface seg_scan_ctrl_if #(
  parameter int unsigned BIN_W = 14
);
  logic             load_valid;
  logic             load_ready;
  logic [BIN_W-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with load handshake.
// Ports: clk, rst (sync, active-high), load (slave handshake),
// bcd_c (next-state display shadow, combinational), ovf (registered,
// set when the last committed value was saturated).
// Accept -> BIN_W CONV cycles -> one COMMIT cycle that updates the shadow.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  seg_scan_ctrl_if.slave              load,
  output logic [NUM_DIGITS*NIB_W-1:0] bcd_c,
  output logic                        ovf
);

  localparam int unsigned BCD_W  = NUM_DIGITS * NIB_W;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned STEP_W = $clog2(BIN_W + 1);
  localparam int unsigned MAX    = bcd_max(NUM_DIGITS);

  conv_state_e       state, state_nxt;
  logic [WORK_W-1:0] work, work_nxt, adj;
  logic [STEP_W-1:0] step, step_nxt;
  logic [BCD_W-1:0]  shadow;
  logic              pend, pend_nxt;
  logic              ovf_nxt;
  logic              ready, ready_nxt;

  assign load.load_ready = ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      step   <= '0;
      shadow <= '0;
      pend   <= 1'b0;
      ovf    <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_nxt;
      work   <= work_nxt;
      step   <= step_nxt;
      shadow <= bcd_c;
      pend   <= pend_nxt;
      ovf    <= ovf_nxt;
      ready  <= ready_nxt;
    end
  end

  // Next-state, double-dabble step and commit
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    step_nxt  = step;
    pend_nxt  = pend;
    ovf_nxt   = ovf;
    bcd_c     = shadow;
    adj       = work;
    case (state)
      IDLE: begin
        if (load.load_valid && ready) begin
          state_nxt = CONV;
          step_nxt  = '0;
          if (32'(load.load_data) > MAX) begin
            work_nxt = {BCD_W'(0), BIN_W'(MAX)};
            pend_nxt = 1'b1;
          end else begin
            work_nxt = {BCD_W'(0), load.load_data};
            pend_nxt = 1'b0;
          end
        end
      end
      CONV: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (adj[BIN_W + i*NIB_W +: NIB_W] >= NIB_W'(5))
            adj[BIN_W + i*NIB_W +: NIB_W] = adj[BIN_W + i*NIB_W +: NIB_W] + NIB_W'(3);
        end
        work_nxt = {adj[WORK_W-2:0], 1'b0};
        step_nxt = step + STEP_W'(1);
        if (step == STEP_W'(BIN_W - 1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        // After BIN_W shifts the binary field is empty and the BCD sits on top.
        bcd_c     = work[WORK_W-1 -: BCD_W];
        ovf_nxt   = pend;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: rtl/sevenseg.sv
// Hex-digit to seven-segment glyph decoder, active-low {g,f,e,d,c,b,a}.
// Ports: digit (BCD nibble in), seg_c (combinational glyph out).
// Non-decimal codes decode to a blank glyph.
module sevenseg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] digit,
  output logic [6:0]       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      NIB_W'(0): seg_c = 7'b100_0000;
      NIB_W'(1): seg_c = 7'b111_1001;
      NIB_W'(2): seg_c = 7'b010_0100;
      NIB_W'(3): seg_c = 7'b011_0000;
      NIB_W'(4): seg_c = 7'b001_1001;
      NIB_W'(5): seg_c = 7'b001_0010;
      NIB_W'(6): seg_c = 7'b000_0010;
      NIB_W'(7): seg_c = 7'b111_1000;
      NIB_W'(8): seg_c = 7'b000_0000;
      NIB_W'(9): seg_c = 7'b001_0000;
      default:   seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment display controller.
// Ports: clk, rst (sync, active-high), load (slave handshake carrying the
// binary value), ovf (value was saturated), seg (active-low glyph,
// {g,f,e,d,c,b,a}, registered), an_n (active-low one-hot digit enable,
// registered). Digits are scanned round-robin, SCAN_DIV cycles per slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BIN_W      = 14,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        load,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an_n
);

  localparam int unsigned BCD_W = NUM_DIGITS * NIB_W;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [BCD_W-1:0]      bcd_c;
  logic [PRE_W-1:0]      presc;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  tick;
  logic [NIB_W-1:0]      nib;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  blank;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .bcd_c (bcd_c),
    .ovf   (ovf)
  );

  assign tick    = (presc == PRE_W'(SCAN_DIV - 1));
  assign idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

  // upper_zero[i]: nibble i and every nibble above it are zero
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero      = all_zero && (bcd_c[i*NIB_W +: NIB_W] == '0);
      upper_zero[i] = all_zero;
    end
  end

  // Glyph is chosen for the digit about to be selected, from the
  // next-state shadow, so a coinciding commit is shown immediately.
  assign nib   = bcd_c[idx_nxt*NIB_W +: NIB_W];
  assign blank = (idx_nxt != '0) && upper_zero[idx_nxt];

  sevenseg u_sevenseg (
    .digit (nib),
    .seg_c (glyph)
  );

  // Prescaler, digit index and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= IDX_W'(NUM_DIGITS - 1);
      seg   <= SEG_BLANK;
      an_n  <= '1;
    end else begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick) begin
        idx  <= idx_nxt;
        an_n <= ~(NUM_DIGITS'(1) << idx_nxt);
        seg  <= blank ? SEG_BLANK : glyph;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl (4 digits, 14-bit input, 4-cycle slots).
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned BW = 14;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ovf;
  logic [6:0]    seg;
  logic [ND-1:0] an_n;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl_if #(.BIN_W(BW)) load_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .BIN_W      (BW),
    .SCAN_DIV   (SD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load_if),
    .ovf  (ovf),
    .seg  (seg),
    .an_n (an_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a value and advance through the accepting edge.
  task automatic do_load(input logic [BW-1:0] v);
    int k;
    k = 0;
    while (!load_if.load_ready && k < 60) begin
      step();
      k++;
    end
    tests++;
    if (!load_if.load_ready) begin
      fails++;
      $display("FAIL load_wait load_ready=%0b required=1", load_if.load_ready);
    end
    load_if.load_valid = 1'b1;
    load_if.load_data  = v;
    step();
    load_if.load_valid = 1'b0;
  endtask

  // Wait for the conversion to finish, let one full refresh pass, then
  // record the glyph shown in each digit slot.
  task automatic settle_capture(output logic [ND-1:0][6:0] segs, output bit ok);
    logic [ND-1:0] seen;
    logic [ND-1:0] pat;
    int k;
    seen = '0;
    segs = '1;
    k = 0;
    while (!load_if.load_ready && k < 60) begin
      step();
      k++;
    end
    repeat (16) step();
    for (int n = 0; n < 24; n++) begin
      for (int d = 0; d < int'(ND); d++) begin
        pat = ND'(1) << d;
        if (an_n == ~pat) begin
          segs[d] = seg;
          seen[d] = 1'b1;
        end
      end
      step();
    end
    ok = load_if.load_ready && (&seen);
  endtask

  task automatic test_reset();
    load_if.load_valid = 1'b0;
    load_if.load_data  = '0;
    rst = 1'b1;
    repeat (3) step();
    tests++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h expected 7f", seg); end
    tests++; if (an_n !== 4'b1111) begin fails++; $display("FAIL reset_an got %b expected 1111", an_n); end
    tests++; if (load_if.load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b expected 1", load_if.load_ready); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    rst = 1'b0;
    repeat (3) step();
    tests++; if (an_n !== 4'b1111) begin fails++; $display("FAIL early_tick an_n got %b expected 1111", an_n); end
    step();
    tests++; if (an_n !== 4'b1110) begin fails++; $display("FAIL first_tick an_n got %b expected 1110", an_n); end
    tests++; if (seg !== 7'b100_0000) begin fails++; $display("FAIL first_tick seg got %b expected 1000000", seg); end
  endtask

  task automatic test_normal_load();
    logic [ND-1:0][6:0] segs, want;
    bit ok;
    int cnt;
    want = {7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001};
    do_load(BW'(1234));
    cnt = 0;
    while (!load_if.load_ready && cnt < 40) begin
      cnt++;
      step();
    end
    tests++; if (cnt != 15) begin fails++; $display("FAIL busy_cycles got %0d expected 15", cnt); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL norm_ovf got %b expected 0", ovf); end
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL norm_scan got %b expected 1", ok); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== want[d]) begin fails++; $display("FAIL norm_d%0d got %b expected %b", d, segs[d], want[d]); end
    end
  endtask

  task automatic test_blanking();
    logic [ND-1:0][6:0] segs, want;
    bit ok;
    want = {7'h7F, 7'h7F, 7'h7F, 7'b111_1000};
    do_load(BW'(7));
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL blank_scan got %b expected 1", ok); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== want[d]) begin fails++; $display("FAIL blank_d%0d got %b expected %b", d, segs[d], want[d]); end
    end
  endtask

  task automatic test_overflow();
    logic [ND-1:0][6:0] segs;
    bit ok;
    do_load(BW'(12000));
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_scan got %b expected 1", ok); end
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set got %b expected 1", ovf); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== 7'b001_0000) begin fails++; $display("FAIL ovf_d%0d got %b expected 0010000", d, segs[d]); end
    end
    do_load(BW'(5));
    settle_capture(segs, ok);
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b expected 0", ovf); end
    tests++; if (segs[0] !== 7'b001_0010) begin fails++; $display("FAIL five_d0 got %b expected 0010010", segs[0]); end
    tests++; if (segs[1] !== 7'h7F) begin fails++; $display("FAIL five_d1 got %b expected 1111111", segs[1]); end
  endtask

  task automatic test_held_valid();
    logic [ND-1:0][6:0] segs, want;
    bit ok;
    int n;
    want = {7'h7F, 7'h7F, 7'b001_1001, 7'b010_0100};
    n = 0;
    while (!load_if.load_ready && n < 60) begin
      step();
      n++;
    end
    load_if.load_valid = 1'b1;
    load_if.load_data  = BW'(1234);
    step();
    load_if.load_data  = BW'(42);
    n = 0;
    do begin
      step();
      n++;
    end while (!load_if.load_ready && n < 40);
    tests++; if (n + 1 != 16) begin fails++; $display("FAIL accept_gap got %0d expected 16", n + 1); end
    step();
    load_if.load_valid = 1'b0;
    tests++; if (load_if.load_ready !== 1'b0) begin fails++; $display("FAIL second_accept ready got %b expected 0", load_if.load_ready); end
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL held_scan got %b expected 1", ok); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== want[d]) begin fails++; $display("FAIL held_d%0d got %b expected %b", d, segs[d], want[d]); end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [ND-1:0][6:0] segs, want;
    bit ok;
    want = {7'h7F, 7'h7F, 7'h7F, 7'b100_0000};
    do_load(BW'(9876));
    repeat (5) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    tests++; if (load_if.load_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b expected 1", load_if.load_ready); end
    tests++; if (an_n !== 4'b1111) begin fails++; $display("FAIL midrst_an got %b expected 1111", an_n); end
    repeat (4) step();
    tests++; if (an_n !== 4'b1110) begin fails++; $display("FAIL midrst_tick an_n got %b expected 1110", an_n); end
    tests++; if (seg !== 7'b100_0000) begin fails++; $display("FAIL midrst_d0 got %b expected 1000000", seg); end
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_scan got %b expected 1", ok); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== want[d]) begin fails++; $display("FAIL midrst_d%0d got %b expected %b", d, segs[d], want[d]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ND-1:0][6:0] segs, want;
    bit ok;
    want = {7'b001_0000, 7'b000_0000, 7'b111_1000, 7'b000_0010};
    do_load(BW'(9876));
    settle_capture(segs, ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_scan got %b expected 1", ok); end
    for (int d = 0; d < int'(ND); d++) begin
      tests++;
      if (segs[d] !== want[d]) begin fails++; $display("FAIL b2b_d%0d got %b expected %b", d, segs[d], want[d]); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_blanking();
    test_overflow();
    test_held_valid();
    test_reset_mid_conv();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
